// File: rtl/lab2_pkg.sv
// lab2 select-mux path: shared defaults and types.
// Imported by the demux router and its channel buffer.
package lab2_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_NOUT  = 2;

  typedef logic [DEF_WIDTH-1:0] word_t;

endpackage

// File: rtl/lab2_demux_buf.sv
// lab2 demux channel buffer: 2-entry FIFO.
// The head register drives data_out directly.
module lab2_demux_buf
  import lab2_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] data_in,
  output logic             full,
  output logic             valid,
  input  logic             ready,
  output logic [WIDTH-1:0] data_out,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;
  logic [1:0]       cnt_q, cnt_d;
  logic             pop;

  assign pop      = (cnt_q != 2'd0) && ready;
  assign full     = (cnt_q == 2'd2);
  assign valid    = (cnt_q != 2'd0);
  assign data_out = head_q;
  assign count    = cnt_q;

  // Next state: head refills from tail or input.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    case (cnt_q)
      2'd0: begin
        if (push) begin
          head_d = data_in;
          cnt_d  = 2'd1;
        end
      end
      2'd1: begin
        if (push && pop) begin
          head_d = data_in;
        end else if (push) begin
          tail_d = data_in;
          cnt_d  = 2'd2;
        end else if (pop) begin
          cnt_d  = 2'd0;
        end
      end
      2'd2: begin
        if (pop) begin
          head_d = tail_q;
          if (push) tail_d = data_in;
          else      cnt_d  = 2'd1;
        end
      end
      default: cnt_d = 2'd0;
    endcase
  end

  // Storage and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/lab2_demux_router.sv
// lab2 demux router: steers a valid/ready stream
// to NOUT independently buffered channels.
module lab2_demux_router
  import lab2_pkg::*;
#(
  parameter  int WIDTH = DEF_WIDTH,
  parameter  int NOUT  = DEF_NOUT,
  localparam int SELW  = $clog2(NOUT)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [WIDTH-1:0]      in_data,
  input  logic [SELW-1:0]       in_sel,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [NOUT*WIDTH-1:0] out_data,
  output logic [NOUT-1:0]       out_valid,
  input  logic [NOUT-1:0]       out_ready,
  output logic                  sel_err,
  input  logic                  err_clr
);

  logic [NOUT-1:0] full;
  logic [NOUT-1:0] push;
  logic [1:0]      cnt_unused [NOUT];
  logic            drop;
  logic            sel_err_q, sel_err_d;

  // Select decode: ready mux and push strobes.
  always_comb begin
    in_ready = 1'b1;
    push     = '0;
    drop     = in_valid;
    for (int k = 0; k < NOUT; k++) begin
      if (in_sel == SELW'(k)) begin
        in_ready = !full[k];
        push[k]  = in_valid && !full[k];
        drop     = 1'b0;
      end
    end
  end

  for (genvar k = 0; k < NOUT; k++) begin : g_ch
    lab2_demux_buf #(
      .WIDTH (WIDTH)
    ) u_buf (
      .clk      (clk),
      .rst_n    (rst_n),
      .push     (push[k]),
      .data_in  (in_data),
      .full     (full[k]),
      .valid    (out_valid[k]),
      .ready    (out_ready[k]),
      .data_out (out_data[k*WIDTH +: WIDTH]),
      .count    (cnt_unused[k])
    );
  end

  // Sticky error: a dropped word beats a clear.
  always_comb begin
    sel_err_d = sel_err_q;
    if (drop)         sel_err_d = 1'b1;
    else if (err_clr) sel_err_d = 1'b0;
  end

  // Error flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sel_err_q <= 1'b0;
    else        sel_err_q <= sel_err_d;
  end

  assign sel_err = sel_err_q;

endmodule

// File: tb/tb_lab2_demux_router.sv
// Bench for lab2_demux_router: NOUT=2 and NOUT=3
// instances, per-channel scoreboard queues.
module tb_lab2_demux_router;
  import lab2_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [7:0]  in_data;
  logic        in_sel;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out_data;
  logic [1:0]  out_valid;
  logic [1:0]  out_ready;
  logic        sel_err;
  logic        err_clr;

  logic [7:0]  in_data3;
  logic [1:0]  in_sel3;
  logic        in_valid3;
  logic        in_ready3;
  logic [23:0] out_data3;
  logic [2:0]  out_valid3;
  logic [2:0]  out_ready3;
  logic        sel_err3;
  logic        err_clr3;

  int n_cmp = 0;
  int n_bad = 0;
  word_t q0[$];
  word_t q1[$];

  lab2_demux_router #(.WIDTH(8), .NOUT(2)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_sel(in_sel),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready),
    .sel_err(sel_err), .err_clr(err_clr)
  );

  lab2_demux_router #(.WIDTH(8), .NOUT(3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data3), .in_sel(in_sel3),
    .in_valid(in_valid3), .in_ready(in_ready3),
    .out_data(out_data3), .out_valid(out_valid3),
    .out_ready(out_ready3),
    .sel_err(sel_err3), .err_clr(err_clr3)
  );

  // Scoreboard: pop on output transfer, push on input transfer.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      for (int k = 0; k < 2; k++) begin
        if (out_valid[k] && out_ready[k]) begin
          word_t got;
          word_t exp;
          got = out_data[k*8 +: 8];
          n_cmp++;
          if ((k == 0 && q0.size() == 0) ||
              (k == 1 && q1.size() == 0)) begin
            n_bad++;
            $display("FAIL sb_ch%0d: got %h, required no word",
                     k, got);
          end else begin
            if (k == 0) exp = q0.pop_front();
            else        exp = q1.pop_front();
            if (got !== exp) begin
              n_bad++;
              $display("FAIL sb_ch%0d: got %h, required %h",
                       k, got, exp);
            end
          end
        end
      end
      if (in_valid && in_ready) begin
        if (in_sel == 1'b0) q0.push_back(in_data);
        else                q1.push_back(in_data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic s, input word_t d);
    bit ok;
    ok = 1'b0;
    in_sel   = s;
    in_data  = d;
    in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL send_timeout: got ready=0, required 1");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (out_valid == 2'b00) break;
    end
    n_cmp++;
    if (out_valid !== 2'b00) begin
      n_bad++;
      $display("FAIL drain: got %b, required 00", out_valid);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 2'b00 || out_data !== 16'h0) begin
      n_bad++;
      $display("FAIL rst_out: got %b/%h, required 00/0000",
               out_valid, out_data);
    end
    n_cmp++;
    if (sel_err !== 1'b0 || sel_err3 !== 1'b0 ||
        out_valid3 !== 3'b000) begin
      n_bad++;
      $display("FAIL rst_err: got %b%b/%b, required 00/000",
               sel_err, sel_err3, out_valid3);
    end
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1 || in_ready3 !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_ready: got %b%b, required 11",
               in_ready, in_ready3);
    end
  endtask

  task automatic test_basic();
    tick();
    out_ready = 2'b11;
    in_sel    = 1'b0;
    in_data   = 8'hA5;
    in_valid  = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL basic_rdy0: got %b, required 1", in_ready);
    end
    tick();
    in_sel  = 1'b1;
    in_data = 8'h3C;
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 2'b01 || out_data[7:0] !== 8'hA5 ||
        in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL basic_ch0: got %b/%h/%b, required 01/a5/1",
               out_valid, out_data[7:0], in_ready);
    end
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 2'b10 || out_data[15:8] !== 8'h3C) begin
      n_bad++;
      $display("FAIL basic_ch1: got %b/%h, required 10/3c",
               out_valid, out_data[15:8]);
    end
    wait_drain();
  endtask

  task automatic test_stall();
    bit ok;
    tick();
    out_ready = 2'b10;
    send_word(1'b0, 8'h01);
    send_word(1'b0, 8'h02);
    in_sel   = 1'b0;
    in_data  = 8'h03;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (in_ready !== 1'b0 || out_valid[0] !== 1'b1 ||
          out_data[7:0] !== 8'h01) begin
        n_bad++;
        $display("FAIL stall_hold: got %b/%b/%h, required 0/1/01",
                 in_ready, out_valid[0], out_data[7:0]);
      end
    end
    tick();
    out_ready = 2'b11;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL stall_release: got ready=0, required 1");
    end
    tick();
    in_valid = 1'b0;
    wait_drain();
  endtask

  task automatic test_no_hol();
    tick();
    out_ready = 2'b00;
    send_word(1'b0, 8'h11);
    send_word(1'b0, 8'h12);
    in_sel   = 1'b1;
    in_data  = 8'h77;
    in_valid = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL hol_rdy: got %b, required 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 2'b11 || out_data !== 16'h7711) begin
      n_bad++;
      $display("FAIL hol_out: got %b/%h, required 11/7711",
               out_valid, out_data);
    end
    tick();
    out_ready = 2'b11;
    wait_drain();
  endtask

  task automatic test_sel_err();
    tick();
    out_ready3 = 3'b111;
    in_sel3    = 2'd3;
    in_data3   = 8'hFF;
    in_valid3  = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (in_ready3 !== 1'b1) begin
      n_bad++;
      $display("FAIL err_rdy: got %b, required 1", in_ready3);
    end
    tick();
    in_valid3 = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (sel_err3 !== 1'b1 || out_valid3 !== 3'b000) begin
      n_bad++;
      $display("FAIL err_set: got %b/%b, required 1/000",
               sel_err3, out_valid3);
    end
    tick();
    err_clr3 = 1'b1;
    tick();
    err_clr3 = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (sel_err3 !== 1'b0) begin
      n_bad++;
      $display("FAIL err_clr: got %b, required 0", sel_err3);
    end
    tick();
    in_valid3 = 1'b1;
    err_clr3  = 1'b1;
    tick();
    in_valid3 = 1'b0;
    err_clr3  = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (sel_err3 !== 1'b1) begin
      n_bad++;
      $display("FAIL err_setwins: got %b, required 1", sel_err3);
    end
    tick();
    err_clr3  = 1'b1;
    in_sel3   = 2'd2;
    in_data3  = 8'h5C;
    in_valid3 = 1'b1;
    tick();
    err_clr3  = 1'b0;
    in_valid3 = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (out_valid3 !== 3'b100 || out_data3[23:16] !== 8'h5C ||
        sel_err3 !== 1'b0) begin
      n_bad++;
      $display("FAIL err_ch2: got %b/%h/%b, required 100/5c/0",
               out_valid3, out_data3[23:16], sel_err3);
    end
    n_cmp++;
    if (sel_err !== 1'b0) begin
      n_bad++;
      $display("FAIL pow2_err: got %b, required 0", sel_err);
    end
  endtask

  task automatic test_pop_push();
    tick();
    out_ready = 2'b00;
    send_word(1'b1, 8'h20);
    send_word(1'b1, 8'h21);
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 2'b10 || out_data[15:8] !== 8'h20) begin
      n_bad++;
      $display("FAIL pp_full: got %b/%h, required 10/20",
               out_valid, out_data[15:8]);
    end
    tick();
    out_ready = 2'b10;
    for (int i = 0; i < 10; i++) begin
      send_word(1'b1, 8'(8'h30 + i));
      n_cmp++;
      if (out_valid[1] !== 1'b1) begin
        n_bad++;
        $display("FAIL pp_valid%0d: got %b, required 1",
                 i, out_valid[1]);
      end
    end
    wait_drain();
  endtask

  task automatic test_mid_reset();
    tick();
    out_ready  = 2'b00;
    out_ready3 = 3'b000;
    in_sel3    = 2'd3;
    in_valid3  = 1'b1;
    send_word(1'b0, 8'h41);
    in_valid3  = 1'b0;
    send_word(1'b1, 8'h42);
    n_cmp++;
    if (sel_err3 !== 1'b1 || out_valid !== 2'b11) begin
      n_bad++;
      $display("FAIL mr_pre: got %b/%b, required 1/11",
               sel_err3, out_valid);
    end
    in_sel   = 1'b0;
    in_data  = 8'h43;
    in_valid = 1'b1;
    #2;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    q0.delete();
    q1.delete();
    #1;
    n_cmp++;
    if (out_valid !== 2'b00 || out_data !== 16'h0 ||
        sel_err3 !== 1'b0 || out_valid3 !== 3'b000) begin
      n_bad++;
      $display("FAIL mr_async: got %b/%h/%b/%b, required 0s",
               out_valid, out_data, sel_err3, out_valid3);
    end
    tick();
    rst_n     = 1'b1;
    out_ready = 2'b11;
    in_sel    = 1'b1;
    in_data   = 8'h5A;
    in_valid  = 1'b1;
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 2'b10 || out_data !== 16'h5A00) begin
      n_bad++;
      $display("FAIL mr_after: got %b/%h, required 10/5a00",
               out_valid, out_data);
    end
    wait_drain();
  endtask

  initial begin
    rst_n      = 1'b1;
    in_data    = '0;
    in_sel     = '0;
    in_valid   = 1'b0;
    out_ready  = '0;
    err_clr    = 1'b0;
    in_data3   = '0;
    in_sel3    = '0;
    in_valid3  = 1'b0;
    out_ready3 = '0;
    err_clr3   = 1'b0;
    test_reset();
    test_basic();
    test_stall();
    test_no_hol();
    test_sel_err();
    test_pop_push();
    test_mid_reset();
    n_cmp++;
    if (q0.size() != 0 || q1.size() != 0) begin
      n_bad++;
      $display("FAIL sb_left: got %0d/%0d words, required 0/0",
               q0.size(), q1.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
